// File: rtl/pe_ctrl_sequencer_pkg.sv
// Shared PE control definitions: ALU opcode, operand-select encodings, the
// PE control word, program entry layout, sequencer state and size defaults.
// The program entry layout is identical whether or not PE_SEQ_LOOP_EN is
// defined, so stored programs are portable between builds.
package pe_ctrl_sequencer_pkg;

    localparam int unsigned SEQ_DEPTH = 16;
    localparam int unsigned SEQ_RPT_W = 3;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_XOR   = 3'd4,
        ALU_MUL   = 3'd5,
        ALU_PASS0 = 3'd6,
        ALU_PASS1 = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        OPSEL_IN   = 2'd0,
        OPSEL_ACC  = 2'd1,
        OPSEL_ZERO = 2'd2,
        OPSEL_ONE  = 2'd3
    } op_sel_t;

    typedef struct packed {
        alu_op_t alu_op;
        op_sel_t sel_0;
        op_sel_t sel_1;
        logic    acc_en;
    } ctr_signals_t;

    typedef struct packed {
        logic                 last;
        logic [SEQ_RPT_W-1:0] rpt;
        ctr_signals_t         ctrl;
    } prog_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pe_ctrl_sequencer_prog_mem.sv
// Program store for the PE control sequencer: DEPTH entries, synchronous
// write port, combinational read port. Contents are not reset.
module prog_mem
    import pe_ctrl_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = SEQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  prog_entry_t              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output prog_entry_t              rdata
);

    prog_entry_t mem [DEPTH];

    // Synchronous write of one program entry
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pe_ctrl_sequencer.sv
// PE control sequencer: steps through a stored program of PE control words
// on start, pairing each issued word with one accepted operand pair and
// driving the PE array control/operand inputs from registers.
// Optional feature macro: PE_SEQ_LOOP_EN (per-entry repeat counts).
module pe_ctrl_sequencer
    import pe_ctrl_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = SEQ_DEPTH,
    parameter int unsigned RPT_W = SEQ_RPT_W
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  prog_entry_t              prog_wdata,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_op_0,
    input  logic [3:0]               in_op_1,
    output ctr_signals_t             ctr_out,
    output logic [3:0]               op_out_0,
    output logic [3:0]               op_out_1,
    output logic                     pe_en,
    output logic                     pe_clear,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

    seq_state_t   state, state_n;
    logic [AW-1:0] pc, pc_n;
    prog_entry_t  rd_entry;
    logic         mem_we;
    logic         entry_done;
    logic         prog_final;

    ctr_signals_t ctr_n;
    logic [3:0]   op0_n, op1_n;
    logic         en_n, clr_n, done_n, busy_n;

`ifdef PE_SEQ_LOOP_EN
    // Counts issues already made of the current entry; counting up and
    // comparing with mem[pc].rpt is equivalent to loading rpt and counting
    // down, but only needs the single read port at pc.
    logic [RPT_W-1:0] rpt_cnt, rpt_cnt_n;
`endif

    prog_mem #(
        .DEPTH(DEPTH)
    ) u_prog_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(prog_addr),
        .wdata(prog_wdata),
        .raddr(pc),
        .rdata(rd_entry)
    );

    assign in_ready = (state == ST_RUN);

    // Next-state, program counter, repeat and output-register decode
    always_comb begin
        state_n    = state;
        pc_n       = pc;
        ctr_n      = ctr_out;
        op0_n      = op_out_0;
        op1_n      = op_out_1;
        en_n       = 1'b0;
        clr_n      = 1'b0;
        done_n     = 1'b0;
        mem_we     = 1'b0;
        prog_final = rd_entry.last || (pc == PC_LAST);
`ifdef PE_SEQ_LOOP_EN
        rpt_cnt_n  = rpt_cnt;
        entry_done = (rpt_cnt == RPT_W'(rd_entry.rpt));
`else
        entry_done = 1'b1;
`endif

        if (abort) begin
            state_n = ST_IDLE;
            pc_n    = '0;
            clr_n   = 1'b1;
`ifdef PE_SEQ_LOOP_EN
            rpt_cnt_n = '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    mem_we = prog_we;
                    if (start) begin
                        state_n = ST_RUN;
                        pc_n    = '0;
                        clr_n   = 1'b1;
`ifdef PE_SEQ_LOOP_EN
                        rpt_cnt_n = '0;
`endif
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        ctr_n = rd_entry.ctrl;
                        op0_n = in_op_0;
                        op1_n = in_op_1;
                        en_n  = 1'b1;
                        if (entry_done) begin
`ifdef PE_SEQ_LOOP_EN
                            rpt_cnt_n = '0;
`endif
                            if (prog_final) begin
                                state_n = ST_DONE;
                                pc_n    = '0;
                            end else begin
                                pc_n = pc + AW'(1);
                            end
                        end
`ifdef PE_SEQ_LOOP_EN
                        else begin
                            rpt_cnt_n = rpt_cnt + RPT_W'(1);
                        end
`endif
                    end
                end
                ST_DONE: begin
                    done_n  = 1'b1;
                    state_n = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                    pc_n    = '0;
                end
            endcase
        end

        busy_n = (state_n == ST_RUN);
    end

    // State, program counter and registered PE-side outputs
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state    <= ST_IDLE;
            pc       <= '0;
            ctr_out  <= '0;
            op_out_0 <= '0;
            op_out_1 <= '0;
            pe_en    <= 1'b0;
            pe_clear <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            ctr_out  <= ctr_n;
            op_out_0 <= op0_n;
            op_out_1 <= op1_n;
            pe_en    <= en_n;
            pe_clear <= clr_n;
            done     <= done_n;
            busy     <= busy_n;
        end
    end

`ifdef PE_SEQ_LOOP_EN
    // Repeat counter for the current program entry
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rpt_cnt <= '0;
        end else begin
            rpt_cnt <= rpt_cnt_n;
        end
    end
`endif

endmodule

// File: tb/tb_pe_ctrl_sequencer.sv
// Directed bench for pe_ctrl_sequencer: a table of per-cycle vectors plus
// hand-written sequences for the full-depth program, ignored writes during
// RUN and asynchronous reset. Honours PE_SEQ_LOOP_EN for the repeat case.
module tb_pe_ctrl_sequencer;
    import pe_ctrl_sequencer_pkg::*;

    logic         clk;
    logic         rst_l;
    logic         prog_we;
    logic [3:0]   prog_addr;
    prog_entry_t  prog_wdata;
    logic         start;
    logic         abort;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   in_op_0;
    logic [3:0]   in_op_1;
    ctr_signals_t ctr_out;
    logic [3:0]   op_out_0;
    logic [3:0]   op_out_1;
    logic         pe_en;
    logic         pe_clear;
    logic         busy;
    logic         done;

    int n_vec = 0;
    int n_bad = 0;

    pe_ctrl_sequencer #(
        .DEPTH(16),
        .RPT_W(3)
    ) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_wdata(prog_wdata),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op_0   (in_op_0),
        .in_op_1   (in_op_1),
        .ctr_out   (ctr_out),
        .op_out_0  (op_out_0),
        .op_out_1  (op_out_1),
        .pe_en     (pe_en),
        .pe_clear  (pe_clear),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        we;
        logic [3:0]  addr;
        prog_entry_t wd;
        logic        s;
        logic        ab;
        logic        iv;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [20:0] exp;
    } vec_t;

    vec_t tbl[$];

    // Expected output word: {pe_en, pe_clear, done, busy, in_ready, ctr_out, op_out_0, op_out_1}
    function automatic logic [20:0] E(logic en, logic clr, logic dn, logic bsy, logic rdy,
                                      logic [7:0] c, logic [3:0] o0, logic [3:0] o1);
        return {en, clr, dn, bsy, rdy, c, o0, o1};
    endfunction

    function automatic logic [20:0] got();
        return {pe_en, pe_clear, done, busy, in_ready, ctr_out, op_out_0, op_out_1};
    endfunction

    function automatic prog_entry_t ent(logic last, logic [2:0] rpt, logic [7:0] c);
        prog_entry_t e;
        e.last = last;
        e.rpt  = rpt;
        e.ctrl = ctr_signals_t'(c);
        return e;
    endfunction

    function automatic vec_t row(string nm, logic rst, logic we, logic [3:0] addr, prog_entry_t wd,
                                 logic s, logic ab, logic iv, logic [3:0] a, logic [3:0] b,
                                 logic [20:0] exp);
        vec_t v;
        v.name = nm; v.rst = rst; v.we = we; v.addr = addr; v.wd = wd;
        v.s = s; v.ab = ab; v.iv = iv; v.a = a; v.b = b; v.exp = exp;
        return v;
    endfunction

    function automatic vec_t R(string nm);
        return row(nm, 1'b1, 1'b0, 4'd0, '0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, '0);
    endfunction

    function automatic vec_t W(string nm, logic [3:0] addr, prog_entry_t e, logic [20:0] exp);
        return row(nm, 1'b0, 1'b1, addr, e, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, exp);
    endfunction

    function automatic vec_t C(string nm, logic s, logic ab, logic iv, logic [3:0] a, logic [3:0] b,
                               logic [20:0] exp);
        return row(nm, 1'b0, 1'b0, 4'd0, '0, s, ab, iv, a, b, exp);
    endfunction

    task automatic check(input string nm, input logic [20:0] g, input logic [20:0] exp);
        n_vec++;
        if (g !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, g, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst_l      = !v.rst;
        prog_we    = v.we;
        prog_addr  = v.addr;
        prog_wdata = v.wd;
        start      = v.s;
        abort      = v.ab;
        in_valid   = v.iv;
        in_op_0    = v.a;
        in_op_1    = v.b;
        @(posedge clk);
        #1;
        check(v.name, got(), v.exp);
    endtask

    task automatic cyc(input logic s, input logic ab, input logic iv, input logic [3:0] a,
                       input logic [3:0] b);
        @(negedge clk);
        rst_l = 1'b1; prog_we = 1'b0; start = s; abort = ab; in_valid = iv;
        in_op_0 = a; in_op_1 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] addr, input prog_entry_t e);
        @(negedge clk);
        rst_l = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        prog_we = 1'b1; prog_addr = addr; prog_wdata = e;
        @(posedge clk);
        #1;
        prog_we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_l = 1'b0; prog_we = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    function automatic logic [7:0] full_ctrl(int unsigned i);
        return {4'(i), 4'(15 - i)};
    endfunction

    initial begin
        rst_l = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_op_0 = '0; in_op_1 = '0;
        #2;
        check("reset_state", got(), '0);

        // three-entry program, in_valid held high
        tbl.push_back(R("t1_rst"));
        tbl.push_back(W("t1_w0", 4'd0, ent(1'b0, 3'd0, 8'h11), '0));
        tbl.push_back(W("t1_w1", 4'd1, ent(1'b0, 3'd0, 8'h22), '0));
        tbl.push_back(W("t1_w2", 4'd2, ent(1'b1, 3'd0, 8'h33), '0));
        tbl.push_back(C("t1_start", 1, 0, 0, 4'd0, 4'd0, E(0,1,0,1,1, 8'h00, 4'd0, 4'd0)));
        tbl.push_back(C("t1_i0",    0, 0, 1, 4'd1, 4'd2, E(1,0,0,1,1, 8'h11, 4'd1, 4'd2)));
        tbl.push_back(C("t1_i1",    0, 0, 1, 4'd3, 4'd4, E(1,0,0,1,1, 8'h22, 4'd3, 4'd4)));
        tbl.push_back(C("t1_i2",    0, 0, 1, 4'd5, 4'd6, E(1,0,0,0,0, 8'h33, 4'd5, 4'd6)));
        tbl.push_back(C("t1_done",  0, 0, 1, 4'd7, 4'd8, E(0,0,1,0,0, 8'h33, 4'd5, 4'd6)));
        tbl.push_back(C("t1_idle",  0, 0, 0, 4'd0, 4'd0, E(0,0,0,0,0, 8'h33, 4'd5, 4'd6)));
        // stall of two cycles after the first accept
        tbl.push_back(C("s_start",  1, 0, 0, 4'd0, 4'd0, E(0,1,0,1,1, 8'h33, 4'd5, 4'd6)));
        tbl.push_back(C("s_i0",     0, 0, 1, 4'd1, 4'd1, E(1,0,0,1,1, 8'h11, 4'd1, 4'd1)));
        tbl.push_back(C("s_st0",    0, 0, 0, 4'd9, 4'd9, E(0,0,0,1,1, 8'h11, 4'd1, 4'd1)));
        tbl.push_back(C("s_st1",    0, 0, 0, 4'd9, 4'd9, E(0,0,0,1,1, 8'h11, 4'd1, 4'd1)));
        tbl.push_back(C("s_i1",     0, 0, 1, 4'd2, 4'd2, E(1,0,0,1,1, 8'h22, 4'd2, 4'd2)));
        tbl.push_back(C("s_i2",     0, 0, 1, 4'd3, 4'd3, E(1,0,0,0,0, 8'h33, 4'd3, 4'd3)));
        tbl.push_back(C("s_done",   0, 0, 0, 4'd0, 4'd0, E(0,0,1,0,0, 8'h33, 4'd3, 4'd3)));
        // abort together with the second accept, then abort beating start
        tbl.push_back(C("a_start",  1, 0, 0, 4'd0, 4'd0, E(0,1,0,1,1, 8'h33, 4'd3, 4'd3)));
        tbl.push_back(C("a_i0",     0, 0, 1, 4'd4, 4'd5, E(1,0,0,1,1, 8'h11, 4'd4, 4'd5)));
        tbl.push_back(C("a_abort",  0, 1, 1, 4'd6, 4'd7, E(0,1,0,0,0, 8'h11, 4'd4, 4'd5)));
        tbl.push_back(C("a_after",  0, 0, 1, 4'd8, 4'd8, E(0,0,0,0,0, 8'h11, 4'd4, 4'd5)));
        tbl.push_back(C("a_abst",   1, 1, 0, 4'd0, 4'd0, E(0,1,0,0,0, 8'h11, 4'd4, 4'd5)));
        tbl.push_back(C("a_idle",   0, 0, 1, 4'd8, 4'd8, E(0,0,0,0,0, 8'h11, 4'd4, 4'd5)));
        // single entry with rpt=2 and last=1
        tbl.push_back(R("r_rst"));
        tbl.push_back(W("r_w0", 4'd0, ent(1'b1, 3'd2, 8'h5A), '0));
        tbl.push_back(C("r_start",  1, 0, 0, 4'd0, 4'd0, E(0,1,0,1,1, 8'h00, 4'd0, 4'd0)));
`ifdef PE_SEQ_LOOP_EN
        tbl.push_back(C("r_i0",     0, 0, 1, 4'd1, 4'd2, E(1,0,0,1,1, 8'h5A, 4'd1, 4'd2)));
        tbl.push_back(C("r_i1",     0, 0, 1, 4'd3, 4'd4, E(1,0,0,1,1, 8'h5A, 4'd3, 4'd4)));
        tbl.push_back(C("r_i2",     0, 0, 1, 4'd5, 4'd6, E(1,0,0,0,0, 8'h5A, 4'd5, 4'd6)));
        tbl.push_back(C("r_done",   0, 0, 1, 4'd7, 4'd7, E(0,0,1,0,0, 8'h5A, 4'd5, 4'd6)));
`else
        tbl.push_back(C("r_i0",     0, 0, 1, 4'd1, 4'd2, E(1,0,0,0,0, 8'h5A, 4'd1, 4'd2)));
        tbl.push_back(C("r_done",   0, 0, 1, 4'd3, 4'd4, E(0,0,1,0,0, 8'h5A, 4'd1, 4'd2)));
        tbl.push_back(C("r_idle",   0, 0, 1, 4'd5, 4'd6, E(0,0,0,0,0, 8'h5A, 4'd1, 4'd2)));
`endif

        foreach (tbl[i]) apply(tbl[i]);

        // full-depth program with no last bit: 16 issues, done, no wrap;
        // a write to entry 5 during RUN must be ignored
        do_reset();
        for (int unsigned i = 0; i < 16; i++) wr(4'(i), ent(1'b0, 3'd0, full_ctrl(i)));
        cyc(1, 0, 0, 4'd0, 4'd0);
        check("f_start", got(), E(0,1,0,1,1, 8'h00, 4'd0, 4'd0));
        for (int unsigned i = 0; i < 16; i++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; in_valid = 1'b1;
            in_op_0 = 4'(i); in_op_1 = 4'(15 - i);
            prog_we = (i == 5); prog_addr = 4'd5; prog_wdata = ent(1'b1, 3'd0, 8'hEE);
            @(posedge clk);
            #1;
            prog_we = 1'b0;
            check($sformatf("f_issue%0d", i), got(),
                  E(1,0,0, i != 15, i != 15, full_ctrl(i), 4'(i), 4'(15 - i)));
        end
        cyc(0, 0, 1, 4'd3, 4'd3);
        check("f_done", got(), E(0,0,1,0,0, full_ctrl(15), 4'd15, 4'd0));
        cyc(0, 0, 1, 4'd3, 4'd3);
        check("f_nowrap", got(), E(0,0,0,0,0, full_ctrl(15), 4'd15, 4'd0));

        // rerun: entry 5 must still hold its original control word
        cyc(1, 0, 0, 4'd0, 4'd0);
        for (int unsigned i = 0; i < 6; i++) begin
            cyc(0, 0, 1, 4'd2, 4'd7);
            check($sformatf("w_rerun%0d", i), got(), E(1,0,0,1,1, full_ctrl(i), 4'd2, 4'd7));
        end
        cyc(0, 1, 0, 4'd0, 4'd0);
        check("w_abort", got(), E(0,1,0,0,0, full_ctrl(5), 4'd2, 4'd7));

        // asynchronous reset while pe_en is high
        cyc(1, 0, 0, 4'd0, 4'd0);
        cyc(0, 0, 1, 4'd9, 4'd1);
        check("x_issue", got(), E(1,0,0,1,1, full_ctrl(0), 4'd9, 4'd1));
        #2;
        rst_l = 1'b0;
        #1;
        check("x_async", got(), '0);
        cyc(0, 0, 1, 4'd9, 4'd1);
        check("x_idle", got(), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/pe_ctrl_sequencer.md
# pe_ctrl_sequencer

Upstream issue stage for the 4-bit PE array. It holds a small program of PE control words, steps through it on `start`, pairs each issued control word with one operand pair taken from an input stream over a valid/ready handshake, and drives `ctr_signals_in`, `en`, `clear`, `in_op_0` and `in_op_1` of the PEs directly. Per-entry repeat counts let one control word be applied to several consecutive operand pairs.

## Interface
Parameters:
- `DEPTH`, 16: program entries; a power of two, at least 2.
- `RPT_W`, 3: repeat-count field width.

Ports:
- `clk` input 1: the single clock.
- `rst_l` input 1: reset, asynchronous and active-low.
- `prog_we` input 1: program write strobe.
- `prog_addr` input $clog2(DEPTH): program write address.
- `prog_wdata` input `prog_entry_t`: fields `last`, `rpt[RPT_W-1:0]`, `ctrl` (`ctr_signals_t`).
- `start` input 1: begin execution at entry 0.
- `abort` input 1: stop execution immediately.
- `in_valid` input 1: operand pair available.
- `in_ready` output 1: operand pair accepted this cycle.
- `in_op_0` input 4: operand 0.
- `in_op_1` input 4: operand 1.
- `ctr_out` output `ctr_signals_t`: goes to the PE `ctr_signals_in`.
- `op_out_0` output 4: goes to PE `in_op_0`.
- `op_out_1` output 4: goes to PE `in_op_1`.
- `pe_en` output 1: goes to PE `en`.
- `pe_clear` output 1: goes to PE `clear`.
- `busy` output 1: state is RUN.
- `done` output 1: one-cycle pulse when the program completes.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `start` -> RUN; `pc` = 0; `rpt_cnt` = mem[0].rpt; `pe_clear` pulses.
  - `prog_we` writes mem[prog_addr].
- RUN:
  - `in_ready` = 1.
  - On `in_valid`, one issue occurs: `ctr_out` <= mem[pc].ctrl, `op_out_*` <= `in_op_*`, and `pe_en` <= 1.
  - Otherwise `pe_en` <= 0 and all other outputs hold.
- Repeat (LOOP_EN set):
  - Entry `pc` is issued `rpt`+1 times.
  - After each issue, if `rpt_cnt` != 0, decrement `rpt_cnt`.
  - Otherwise advance: `pc`+1, and `rpt_cnt` reloads from the new entry.
- End of program:
  - The final issue of an entry with `last`=1 goes to DONE.
  - An entry at `pc`=DEPTH-1 is treated as `last`=1; `pc` never wraps.
- DONE: `done`=1 for one cycle, then IDLE. `ctr_out` and `op_out_*` hold their last values.
- `abort` (any state):
  - Next state IDLE, `pe_clear` pulses, no `done` pulse.
  - `abort` wins over `start`, `in_valid` and `prog_we` in the same cycle. No issue occurs and no write occurs.
- `prog_we` outside IDLE is ignored.
- `start` outside IDLE is ignored.
- Program memory is not reset; its contents are undefined until written.

## Timing
- All outputs are registered except `in_ready`, which is decoded from state.
- `busy` = (state == RUN).
- Reset values: `ctr_out`=0, `op_out_*`=0, `pe_en`=0, `pe_clear`=0, `done`=0, `busy`=0, `in_ready`=0, state IDLE, `pc`=0.
- Start latency: `start` at cycle t gives `busy` from t+1. The first possible accept is at t+1, and its `pe_en` is seen at t+2.
- Issue latency: an accept at cycle t gives `ctr_out`/`op_out`/`pe_en` valid during t+1. The PE latches at the end of t+1, and the ALU result appears at t+2.
- `pe_clear` is high for exactly the one cycle after the `start` or `abort` edge.
- Full throughput: one issue per cycle while `in_valid` is held high.
- `done` is asserted in the cycle after the final issue's output cycle (t+2 relative to the final accept).

## Configuration
- Macro: `PE_SEQ_LOOP_EN`.
- When defined: the `rpt` field is honoured as above.
- When undefined:
  - `rpt` is ignored and each entry is issued exactly once.
  - The `rpt_cnt` register and its logic are not present.
  - The `prog_entry_t` layout is unchanged, so programs stay binary compatible.

## Structure
- `ctr_signals_t`, `alu_op_t` and the operand-select encodings stay in the shared `internal_defines.vh`.
- Add to that file: `prog_entry_t`, `seq_state_t`, and the `DEPTH`/`RPT_W` defaults as constants.
- One natural sub-module, `prog_mem`: `DEPTH`×`$bits(prog_entry_t)` storage with a synchronous write port and a combinational read at `pc`.
- The FSM, `pc`, `rpt_cnt` and the output registers live in the top-level module.

## Test plan
- Reset mid-RUN: drop `rst_l` while `pe_en`=1 -> all outputs are 0 immediately (asynchronously), and the state is IDLE after release.
- Three entries with `rpt`=0, last on entry 2, `in_valid` held high:
  - `pe_en` high for exactly 3 cycles.
  - `ctr_out` = mem0, mem1, mem2, each paired with its operands.
  - `done` pulses one cycle after the third issue.
- Stall: same program with `in_valid` low for 2 cycles after the first accept -> `pe_en` = 1,0,0,1,1 and `ctr_out` holds mem0 through the stall.
- With `PE_SEQ_LOOP_EN`, entry0 `rpt`=2 and `last`=1 -> 3 issues of mem0 with operands (1,2), (3,4), (5,6), then `done`. Without the macro -> 1 issue, then `done`.
- Abort in the same cycle as an accept: `abort` and `in_valid` both high at the 2nd issue -> no 2nd issue, `pe_clear`=1 next cycle, no `done`, and `busy` drops.
- Boundary:
  - 16 entries with no `last` set -> 16 issues, then `done`; `pc` does not wrap.
  - `prog_we` during RUN -> memory unchanged, verified by a rerun.
